// File: rtl/instr_sequencer_if.sv
// Control/handshake bundle between the instruction sequencer and the datapath/memories.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface instr_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [5:0]       op;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_load;
    logic             reg_re;
    logic             alu_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] instr_count;
    logic             fault;
    logic [1:0]       fault_code;
    logic [2:0]       state;

    modport master (
        input  run, op, zero, imem_ready, dmem_ready,
        output imem_req, ir_load, reg_re, alu_en, dmem_req, dmem_we, reg_we,
               wb_sel, pc_write, pc_sel, instr_count, fault, fault_code, state
    );

    modport slave (
        output run, op, zero, imem_ready, dmem_ready,
        input  imem_req, ir_load, reg_re, alu_en, dmem_req, dmem_we, reg_we,
               wb_sel, pc_write, pc_sel, instr_count, fault, fault_code, state
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM with retire counter
// and sticky trap on illegal opcodes or memory handshake timeouts.
module instr_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    instr_sequencer_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] TRAP   = 3'd6;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]       state_q;
    logic [5:0]       op_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0] count_q;
    logic             fault_q;
    logic [1:0]       code_q;

    logic is_r, is_beq, is_lw, is_sw, is_j, is_lui;
    logic retire;
    logic legal_op;

    assign is_r   = (op_q == 6'b000000);
    assign is_beq = (op_q == 6'b000001);
    assign is_lw  = (op_q == 6'b000010) || (op_q == 6'b000110);
    assign is_sw  = (op_q == 6'b000011);
    assign is_j   = (op_q == 6'b000100);
    assign is_lui = (op_q == 6'b000101);

    assign legal_op = (bus.op inside {6'b000000, 6'b000001, 6'b000010, 6'b000011,
                                      6'b000100, 6'b000101, 6'b000110});

    // Every retire cycle is also the only cycle in which pc_write is raised.
    assign retire = ((state_q == EXEC) && (is_beq || is_j)) ||
                    ((state_q == MEM)  && is_sw && bus.dmem_ready) ||
                    (state_q == WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else if (retire) begin
            count_q <= count_q + 1'b1;
            wait_q  <= '0;
            state_q <= bus.run ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.run) begin
                        state_q <= FETCH;
                        wait_q  <= '0;
                    end
                end
                FETCH: begin
                    // A ready in the final allowed cycle still wins over the timeout.
                    if (bus.imem_ready) begin
                        state_q <= DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= TRAP;
                        fault_q <= 1'b1;
                        code_q  <= 2'b10;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                DECODE: begin
                    op_q <= bus.op;
                    if (legal_op) begin
                        state_q <= EXEC;
                    end else begin
                        state_q <= TRAP;
                        fault_q <= 1'b1;
                        code_q  <= 2'b01;
                    end
                end
                EXEC: begin
                    if (is_lw || is_sw) begin
                        state_q <= MEM;
                        wait_q  <= '0;
                    end else begin
                        state_q <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ready) begin
                        state_q <= WB;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= TRAP;
                        fault_q <= 1'b1;
                        code_q  <= 2'b11;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                TRAP:    state_q <= TRAP;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_load  = 1'b0;
        bus.reg_re   = 1'b0;
        bus.alu_en   = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.reg_we   = 1'b0;
        bus.wb_sel   = 2'b00;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 2'b00;
        case (state_q)
            FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_load  = bus.imem_ready;
            end
            DECODE: bus.reg_re = 1'b1;
            EXEC: begin
                bus.alu_en = is_r || is_beq || is_lw || is_sw;
                if (is_beq) begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = bus.zero ? 2'b01 : 2'b00;
                end else if (is_j) begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = 2'b10;
                end
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = is_sw;
                bus.pc_write = is_sw && bus.dmem_ready;
            end
            WB: begin
                bus.reg_we   = 1'b1;
                bus.pc_write = 1'b1;
                bus.wb_sel   = is_lw ? 2'b01 : (is_lui ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
    end

    assign bus.instr_count = count_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-cycle expected control vectors are queued
// as stimulus is driven and compared against the DUT on the falling edge.
module tb_instr_sequencer;
    // A narrow counter keeps the wrap-around boundary reachable in a short run.
    localparam int TB_CNT_W = 8;
    localparam int TIMEOUT  = 15;

    logic clk;
    logic rst;

    instr_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

    instr_sequencer #(.CNT_W(TB_CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [17:0]         exp_q[$];
    logic                exp_fault;
    logic [1:0]          exp_code;
    logic [TB_CNT_W-1:0] exp_count;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Strobe order: imem_req ir_load reg_re alu_en dmem_req dmem_we reg_we
    function automatic logic [17:0] mk(input logic [6:0] strb, input logic [1:0] wb,
                                       input logic pw, input logic [1:0] ps, input logic [2:0] st);
        return {strb, wb, pw, ps, st, exp_fault, exp_code};
    endfunction

    task automatic push_cycle(input logic [17:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            e = exp_q.pop_front();
            check_output("cycle", {bus.imem_req, bus.ir_load, bus.reg_re, bus.alu_en, bus.dmem_req,
                                   bus.dmem_we, bus.reg_we, bus.wb_sel, bus.pc_write, bus.pc_sel,
                                   bus.state, bus.fault, bus.fault_code}, e);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.op = 6'd0;
        bus.zero = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fault = 1'b0;
        exp_code  = 2'b00;
        exp_count = '0;
    endtask

    task automatic start_run();
        bus.run = 1'b1;
        push_cycle(mk(7'b0000000, 2'b00, 1'b0, 2'b00, 3'd0));
    endtask

    // Drives one instruction from FETCH through retire (or trap / reset abort).
    task automatic apply_stimulus(input logic [5:0] opv, input logic z, input int iw, input int dw,
                                  input bit abort_mem, input bit drop_run, output bit trapped);
        logic lw_op, sw_op;
        trapped = 1'b0;
        lw_op = (opv == 6'b000010) || (opv == 6'b000110);
        sw_op = (opv == 6'b000011);
        bus.imem_ready = 1'b0;
        for (int i = 0; i < ((iw >= TIMEOUT) ? TIMEOUT : iw); i++)
            push_cycle(mk(7'b1000000, 2'b00, 1'b0, 2'b00, 3'd1));
        if (iw >= TIMEOUT) begin
            exp_fault = 1'b1; exp_code = 2'b10; trapped = 1'b1;
            return;
        end
        bus.imem_ready = 1'b1;
        push_cycle(mk(7'b1100000, 2'b00, 1'b0, 2'b00, 3'd1));
        bus.imem_ready = 1'b0;
        bus.op = opv;
        if (drop_run) bus.run = 1'b0;
        push_cycle(mk(7'b0010000, 2'b00, 1'b0, 2'b00, 3'd2));
        if (opv > 6'd6) begin
            exp_fault = 1'b1; exp_code = 2'b01; trapped = 1'b1;
            return;
        end
        bus.op = 6'b111111;
        bus.zero = z;
        case (opv)
            6'b000000: begin
                push_cycle(mk(7'b0001000, 2'b00, 1'b0, 2'b00, 3'd3));
                push_cycle(mk(7'b0000001, 2'b00, 1'b1, 2'b00, 3'd5));
            end
            6'b000001: push_cycle(mk(7'b0001000, 2'b00, 1'b1, z ? 2'b01 : 2'b00, 3'd3));
            6'b000100: push_cycle(mk(7'b0000000, 2'b00, 1'b1, 2'b10, 3'd3));
            6'b000101: begin
                push_cycle(mk(7'b0000000, 2'b00, 1'b0, 2'b00, 3'd3));
                push_cycle(mk(7'b0000001, 2'b10, 1'b1, 2'b00, 3'd5));
            end
            default: begin
                push_cycle(mk(7'b0001000, 2'b00, 1'b0, 2'b00, 3'd3));
                bus.dmem_ready = 1'b0;
                if (abort_mem) begin
                    push_cycle(mk({4'b0000, 1'b1, sw_op, 1'b0}, 2'b00, 1'b0, 2'b00, 3'd4));
                    rst = 1'b1;
                    push_cycle(mk({4'b0000, 1'b1, sw_op, 1'b0}, 2'b00, 1'b0, 2'b00, 3'd4));
                    rst = 1'b0;
                    bus.run = 1'b0;
                    exp_count = '0;
                    push_cycle(mk(7'b0000000, 2'b00, 1'b0, 2'b00, 3'd0));
                    return;
                end
                for (int i = 0; i < ((dw >= TIMEOUT) ? TIMEOUT : dw); i++)
                    push_cycle(mk({4'b0000, 1'b1, sw_op, 1'b0}, 2'b00, 1'b0, 2'b00, 3'd4));
                if (dw >= TIMEOUT) begin
                    exp_fault = 1'b1; exp_code = 2'b11; trapped = 1'b1;
                    return;
                end
                bus.dmem_ready = 1'b1;
                push_cycle(mk({4'b0000, 1'b1, sw_op, 1'b0}, 2'b00, sw_op, 2'b00, 3'd4));
                bus.dmem_ready = 1'b0;
                if (lw_op) push_cycle(mk(7'b0000001, 2'b01, 1'b1, 2'b00, 3'd5));
            end
        endcase
        exp_count = exp_count + 1'b1;
        check_output("instr_count", 32'(bus.instr_count), 32'(exp_count));
    endtask

    task automatic expect_trap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.run = i[0];
            bus.imem_ready = 1'b1;
            bus.dmem_ready = 1'b1;
            push_cycle(mk(7'b0000000, 2'b00, 1'b0, 2'b00, 3'd6));
        end
    endtask

    initial begin
        bit tr;
        do_reset();
        push_cycle(mk(7'b0000000, 2'b00, 1'b0, 2'b00, 3'd0));
        check_output("reset_count", 32'(bus.instr_count), 32'd0);
        start_run();

        apply_stimulus(6'b000000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000001, 1'b1, 0, 0, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000001, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000010, 1'b0, 0, 3, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000110, 1'b0, 2, 1, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000011, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000011, 1'b0, 1, 14, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000101, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000100, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000000, 1'b0, 14, 0, 1'b0, 1'b0, tr);

        // run dropped mid-instruction: retire, then park in IDLE until run returns
        apply_stimulus(6'b000000, 1'b0, 0, 0, 1'b0, 1'b1, tr);
        push_cycle(mk(7'b0000000, 2'b00, 1'b0, 2'b00, 3'd0));
        start_run();

        while (exp_count != '1)
            apply_stimulus(6'b000100, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        apply_stimulus(6'b000100, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        check_output("count_wrap", 32'(bus.instr_count), 32'd0);

        apply_stimulus(6'b000010, 1'b0, 0, 0, 1'b1, 1'b0, tr);
        check_output("rst_mem_count", 32'(bus.instr_count), 32'd0);

        start_run();
        apply_stimulus(6'b000000, 1'b0, TIMEOUT, 0, 1'b0, 1'b0, tr);
        check_output("imem_timeout", 32'(tr), 32'd1);
        expect_trap(4);

        do_reset();
        start_run();
        apply_stimulus(6'b000111, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        check_output("illegal_op", 32'(tr), 32'd1);
        expect_trap(4);

        do_reset();
        start_run();
        apply_stimulus(6'b000011, 1'b0, 0, TIMEOUT, 1'b0, 1'b0, tr);
        check_output("dmem_timeout", 32'(tr), 32'd1);
        expect_trap(3);

        do_reset();
        push_cycle(mk(7'b0000000, 2'b00, 1'b0, 2'b00, 3'd0));
        check_output("post_trap_reset", 32'({bus.fault, bus.fault_code}), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
